// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath/memory.
// The master side is the sequencer; the slave side is the datapath that obeys it.
interface multicycle_control_fsm_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic             mem_ready;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             MemtoReg;
    logic             RegDst;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [2:0]       ALUOp;
    logic [1:0]       PCSource;
    logic             illegal_op;
    logic             halted;
    logic [CNT_W-1:0] retired;
    logic [3:0]       state_o;

    modport master (
        input  op, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, illegal_op, halted, retired, state_o
    );

    modport slave (
        output op, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, illegal_op, halted, retired, state_o
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory-ready stall,
// memory timeout halt and a retired-instruction counter.
module multicycle_control_fsm #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_control_fsm_if.master bus
);
    localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_EXEC_I   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SUBI  = 6'b101010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BGT   = 6'b000111;
    localparam logic [5:0] OP_BLT   = 6'b000001;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q;
    logic [CNT_W-1:0]   retired_q;
    logic               halted_q;

    logic timeout;
    logic waiting;
    logic retire;

    assign timeout = (wait_cnt_q == WAIT_W'(MEM_WAIT_MAX)) && !bus.mem_ready;
    assign waiting = ((state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR))
                     && !bus.mem_ready;
    assign retire  = (state_q == S_MEM_WB) || (state_q == S_R_WB) || (state_q == S_I_WB) ||
                     (state_q == S_BRANCH) || (state_q == S_JUMP) ||
                     ((state_q == S_MEM_WR) && bus.mem_ready);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (bus.mem_ready)  state_d = S_DECODE;
                else if (timeout)   state_d = S_HALT;
            end
            S_DECODE: begin
                case (bus.op)
                    OP_RTYPE:                        state_d = S_EXEC_R;
                    OP_ADDI, OP_SUBI:                state_d = S_EXEC_I;
                    OP_LW, OP_SW:                    state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE, OP_BGT, OP_BLT:  state_d = S_BRANCH;
                    OP_J:                            state_d = S_JUMP;
                    default:                         state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: state_d = (bus.op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (bus.mem_ready)  state_d = S_MEM_WB;
                else if (timeout)   state_d = S_HALT;
            end
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR: begin
                if (bus.mem_ready)  state_d = S_FETCH;
                else if (timeout)   state_d = S_HALT;
            end
            S_EXEC_R:   state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_EXEC_I:   state_d = S_I_WB;
            S_I_WB:     state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            retired_q  <= '0;
            halted_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            // The wait counter measures consecutive stall cycles in one state only.
            if (state_d != state_q)
                wait_cnt_q <= '0;
            else if (waiting)
                wait_cnt_q <= wait_cnt_q + 1'b1;
            if (retire)
                retired_q <= retired_q + 1'b1;
            halted_q <= halted_q | (state_d == S_HALT);
        end
    end

    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       memto_reg, reg_dst, reg_write, alu_src_a, illegal;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        memto_reg     = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        illegal       = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        alu_op        = 3'b000;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = bus.mem_ready;
                pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                illegal   = (state_d == S_FETCH);
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_MEM_WB: begin
                memto_reg = 1'b1;
                reg_write = 1'b1;
            end
            S_MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b010;
            end
            S_R_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = (bus.op == OP_SUBI) ? 3'b001 : 3'b000;
            end
            S_I_WB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                case (bus.op)
                    OP_BEQ:  alu_op = 3'b001;
                    OP_BNE:  alu_op = 3'b011;
                    OP_BGT:  alu_op = 3'b111;
                    OP_BLT:  alu_op = 3'b101;
                    default: alu_op = 3'b000;
                endcase
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            default: ;
        endcase
    end

    // Gating with rst_n keeps the Mealy FETCH terms from leaking out while reset is held.
    assign bus.PCWrite     = rst_n & pc_write;
    assign bus.PCWriteCond = rst_n & pc_write_cond;
    assign bus.IorD        = rst_n & iord;
    assign bus.MemRead     = rst_n & mem_read;
    assign bus.MemWrite    = rst_n & mem_write;
    assign bus.IRWrite     = rst_n & ir_write;
    assign bus.MemtoReg    = rst_n & memto_reg;
    assign bus.RegDst      = rst_n & reg_dst;
    assign bus.RegWrite    = rst_n & reg_write;
    assign bus.ALUSrcA     = rst_n & alu_src_a;
    assign bus.illegal_op  = rst_n & illegal;
    assign bus.ALUSrcB     = {2{rst_n}} & alu_src_b;
    assign bus.PCSource    = {2{rst_n}} & pc_source;
    assign bus.ALUOp       = {3{rst_n}} & alu_op;
    assign bus.halted      = halted_q;
    assign bus.retired     = retired_q;
    assign bus.state_o     = state_q;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for the multi-cycle sequencer; a narrow retired counter makes the wrap reachable.
module tb_multicycle_control_fsm;
    localparam int CNT_W = 4;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_SUB = 6'b101010;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BGT = 6'b000111;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_control_fsm_if #(.CNT_W(CNT_W)) bus ();

    multicycle_control_fsm #(.MEM_WAIT_MAX(15), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int start_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock cycle: inputs change on the falling edge, outputs are sampled 1 ns later.
    task automatic cyc(input logic [5:0] op, input logic rdy);
        @(negedge clk);
        bus.op        = op;
        bus.mem_ready = rdy;
        cyc_cnt++;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc_cnt++;
        #1;
    endtask

    initial begin
        bus.op        = OP_R;
        bus.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_state",   32'(bus.state_o), 0);
        check("rst_memread", 32'(bus.MemRead), 0);
        check("rst_irwrite", 32'(bus.IRWrite), 0);
        check("rst_retired", 32'(bus.retired), 0);
        check("rst_halted",  32'(bus.halted),  0);

        // R-type, zero-wait
        release_reset();
        check("r_fetch_state",   32'(bus.state_o), 0);
        check("r_fetch_memread", 32'(bus.MemRead), 1);
        check("r_fetch_irwrite", 32'(bus.IRWrite), 1);
        check("r_fetch_pcwrite", 32'(bus.PCWrite), 1);
        check("r_fetch_srcb",    32'(bus.ALUSrcB), 1);
        cyc(OP_R, 1'b1);
        check("r_dec_state",  32'(bus.state_o),  1);
        check("r_dec_srcb",   32'(bus.ALUSrcB),  3);
        check("r_dec_regwr",  32'(bus.RegWrite), 0);
        cyc(OP_R, 1'b1);
        check("r_exec_state", 32'(bus.state_o),  6);
        check("r_exec_aluop", 32'(bus.ALUOp),    2);
        check("r_exec_srca",  32'(bus.ALUSrcA),  1);
        check("r_exec_regwr", 32'(bus.RegWrite), 0);
        cyc(OP_R, 1'b1);
        check("r_wb_state",   32'(bus.state_o),  7);
        check("r_wb_regwr",   32'(bus.RegWrite), 1);
        check("r_wb_regdst",  32'(bus.RegDst),   1);
        cyc(OP_LW, 1'b1);
        start_cyc = cyc_cnt;
        check("r_done_state",   32'(bus.state_o), 0);
        check("r_done_retired", 32'(bus.retired), 1);
        $display("txn R-type retired=%0d", bus.retired);

        // LW with three stall cycles in MEM_RD
        cyc(OP_LW, 1'b1);
        check("lw_dec_state", 32'(bus.state_o), 1);
        cyc(OP_LW, 1'b1);
        check("lw_addr_state", 32'(bus.state_o), 2);
        check("lw_addr_srcb",  32'(bus.ALUSrcB), 2);
        for (int i = 0; i < 3; i++) begin
            cyc(OP_LW, 1'b0);
            check("lw_rd_state",   32'(bus.state_o), 3);
            check("lw_rd_memread", 32'(bus.MemRead), 1);
            check("lw_rd_iord",    32'(bus.IorD),    1);
        end
        cyc(OP_LW, 1'b1);
        check("lw_rd_ready_memread", 32'(bus.MemRead), 1);
        cyc(OP_LW, 1'b1);
        check("lw_wb_state",    32'(bus.state_o),  4);
        check("lw_wb_memtoreg", 32'(bus.MemtoReg), 1);
        check("lw_wb_regwr",    32'(bus.RegWrite), 1);
        cyc(OP_BGT, 1'b1);
        check("lw_latency",     32'(cyc_cnt - start_cyc), 8);
        check("lw_done_retired", 32'(bus.retired), 2);
        $display("txn LW retired=%0d cycles=%0d", bus.retired, cyc_cnt - start_cyc);

        // BGT then J
        cyc(OP_BGT, 1'b1);
        cyc(OP_BGT, 1'b1);
        check("bgt_state",    32'(bus.state_o),     10);
        check("bgt_aluop",    32'(bus.ALUOp),       7);
        check("bgt_pccond",   32'(bus.PCWriteCond), 1);
        check("bgt_pcsource", 32'(bus.PCSource),    1);
        check("bgt_pcwrite",  32'(bus.PCWrite),     0);
        cyc(OP_J, 1'b1);
        check("bgt_retired", 32'(bus.retired), 3);
        $display("txn BGT retired=%0d", bus.retired);
        cyc(OP_J, 1'b1);
        cyc(OP_J, 1'b1);
        check("j_state",    32'(bus.state_o),  11);
        check("j_pcwrite",  32'(bus.PCWrite),  1);
        check("j_pcsource", 32'(bus.PCSource), 2);
        cyc(OP_BAD, 1'b1);
        check("j_retired", 32'(bus.retired), 4);
        $display("txn J retired=%0d", bus.retired);

        // Illegal opcode
        cyc(OP_BAD, 1'b1);
        check("ill_state", 32'(bus.state_o),    1);
        check("ill_pulse", 32'(bus.illegal_op), 1);
        cyc(OP_SUB, 1'b1);
        check("ill_back_state", 32'(bus.state_o),    0);
        check("ill_back_pulse", 32'(bus.illegal_op), 0);
        check("ill_retired",    32'(bus.retired),    4);
        $display("txn illegal retired=%0d", bus.retired);

        // SUBI
        cyc(OP_SUB, 1'b1);
        cyc(OP_SUB, 1'b1);
        check("subi_state", 32'(bus.state_o), 8);
        check("subi_aluop", 32'(bus.ALUOp),   1);
        check("subi_srcb",  32'(bus.ALUSrcB), 2);
        cyc(OP_SUB, 1'b1);
        check("subi_wb_state",  32'(bus.state_o),  9);
        check("subi_wb_regwr",  32'(bus.RegWrite), 1);
        check("subi_wb_regdst", 32'(bus.RegDst),   0);
        cyc(OP_SW, 1'b1);
        check("subi_retired", 32'(bus.retired), 5);
        $display("txn SUBI retired=%0d", bus.retired);

        // SW, zero wait
        cyc(OP_SW, 1'b1);
        cyc(OP_SW, 1'b1);
        cyc(OP_SW, 1'b1);
        check("sw_state",    32'(bus.state_o),  5);
        check("sw_memwrite", 32'(bus.MemWrite), 1);
        check("sw_iord",     32'(bus.IorD),     1);

        // FETCH stalls 15 cycles, ready arrives on the limit cycle
        cyc(OP_BAD, 1'b0);
        check("sw_retired", 32'(bus.retired), 6);
        $display("txn SW retired=%0d", bus.retired);
        for (int i = 0; i < 14; i++) cyc(OP_BAD, 1'b0);
        check("limit_pre_state", 32'(bus.state_o), 0);
        cyc(OP_BAD, 1'b1);
        check("limit_irwrite", 32'(bus.IRWrite), 1);
        cyc(OP_BAD, 1'b1);
        check("limit_decode_state", 32'(bus.state_o), 1);
        $display("txn ready-on-limit state=%0d", bus.state_o);

        // FETCH stalls 16 cycles -> HALT
        for (int i = 0; i < 16; i++) cyc(OP_R, 1'b0);
        check("halt_pre_state", 32'(bus.state_o), 0);
        cyc(OP_R, 1'b1);
        check("halt_state",   32'(bus.state_o), 12);
        check("halt_flag",    32'(bus.halted),  1);
        check("halt_memread", 32'(bus.MemRead), 0);
        check("halt_irwrite", 32'(bus.IRWrite), 0);
        repeat (3) cyc(OP_R, 1'b1);
        check("halt_sticky_state", 32'(bus.state_o), 12);
        check("halt_sticky_flag",  32'(bus.halted),  1);
        $display("txn timeout halted=%0d", bus.halted);

        // Reset out of HALT, then reset in the middle of a stalled SW
        @(negedge clk);
        rst_n = 1'b0;
        bus.op = OP_J;
        bus.mem_ready = 1'b1;
        #1;
        check("halt_rst_flag",  32'(bus.halted),  0);
        check("halt_rst_state", 32'(bus.state_o), 0);
        release_reset();
        cyc(OP_J, 1'b1);
        cyc(OP_J, 1'b1);
        cyc(OP_SW, 1'b1);
        check("pre_sw_retired", 32'(bus.retired), 1);
        cyc(OP_SW, 1'b1);
        cyc(OP_SW, 1'b1);
        cyc(OP_SW, 1'b0);
        check("swrst_memwrite_before", 32'(bus.MemWrite), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("swrst_memwrite", 32'(bus.MemWrite), 0);
        check("swrst_state",    32'(bus.state_o),  0);
        check("swrst_retired",  32'(bus.retired),  0);
        check("swrst_regwr",    32'(bus.RegWrite), 0);
        $display("txn reset-mid-SW state=%0d", bus.state_o);

        // Retired counter wrap (4-bit): 15 jumps -> 15, one more -> 0
        bus.op = OP_J;
        bus.mem_ready = 1'b1;
        release_reset();
        for (int i = 1; i <= 16; i++) begin
            cyc(OP_J, 1'b1);
            cyc(OP_J, 1'b1);
            cyc(OP_J, 1'b1);
            if (i == 15) check("wrap_full", 32'(bus.retired), 15);
        end
        check("wrap_zero", 32'(bus.retired), 0);
        $display("txn wrap retired=%0d", bus.retired);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
